// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch unit: PC issue, in-order memory responses, prefetch FIFO
// Define IF_PERF_CNT_EN to build the perf_fetched / perf_bubble counters.
module if_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter int                INSTR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_pc_inc,
  output logic [INSTR_W-1:0] out_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubble
`endif
);

  localparam int                PTR_W   = $clog2(FIFO_DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_W / 8);
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  rsp_pc;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   drop_cnt;
  logic [CNT_W-1:0]   fifo_count;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]  pc_mem    [FIFO_DEPTH];
  logic [INSTR_W-1:0] instr_mem [FIFO_DEPTH];

  logic [CNT_W:0] in_use;
  logic           issue;
  logic           rsp_ok;
  logic           push;
  logic           pop;
  logic           fifo_nonempty;

  // Reserving a FIFO slot per outstanding request means a push can never overflow.
  always_comb begin
    in_use         = {1'b0, fifo_count} + {1'b0, outstanding};
    fifo_nonempty  = (fifo_count != '0);
    imem_req_valid = !rst && !redirect_valid && (in_use < DEPTH_C);
    imem_req_addr  = fetch_pc;
    issue          = imem_req_valid && imem_req_ready;
    rsp_ok         = imem_rsp_valid && (outstanding != '0);
    push           = rsp_ok && !redirect_valid && (drop_cnt == '0);
    out_valid      = !rst && !redirect_valid && fifo_nonempty;
    pop            = out_valid && out_ready;
  end

  always_comb begin
    out_pc    = RESET_PC;
    out_instr = '0;
    if (!rst) begin
      out_pc = fifo_nonempty ? pc_mem[rd_ptr] : rsp_pc;
      if (fifo_nonempty) out_instr = instr_mem[rd_ptr];
    end
    out_pc_inc = out_pc + PC_STEP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (issue && !rsp_ok)      outstanding <= outstanding + CNT_W'(1);
      else if (!issue && rsp_ok) outstanding <= outstanding - CNT_W'(1);

      if (redirect_valid) begin
        fetch_pc   <= redirect_addr;
        rsp_pc     <= redirect_addr;
        fifo_count <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        // Every request still in flight is stale, including ones already marked for dropping.
        drop_cnt   <= rsp_ok ? outstanding - CNT_W'(1) : outstanding;
      end else begin
        if (issue) fetch_pc <= fetch_pc + PC_STEP;
        if (rsp_ok && drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          rsp_pc <= rsp_pc + PC_STEP;
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      fifo_count <= fifo_count + CNT_W'(1);
        else if (!push && pop) fifo_count <= fifo_count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= imem_rsp_data;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubble  <= '0;
    end else begin
      if (pop && perf_fetched != 32'hFFFF_FFFF) perf_fetched <= perf_fetched + 32'd1;
      if (out_ready && !out_valid && perf_bubble != 32'hFFFF_FFFF) perf_bubble <= perf_bubble + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit with a fixed-latency memory model
`timescale 1ns/1ps
module tb_if_fetch_unit;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_inc;
  logic [31:0] out_instr;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubble;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(
    .ADDR_W(32), .INSTR_W(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_inc(out_pc_inc), .out_instr(out_instr)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_bubble(perf_bubble)
`endif
  );

  typedef struct { int due; logic [31:0] data; } rsp_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc;
  int          latency;
  rsp_t        mq[$];
  logic [31:0] exp_pc;
  int          n_pops;
  int          n_bubbles;
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_inc_log[$];
  logic        s_out_valid, s_req_valid;
  logic [31:0] s_out_pc, s_out_inc, s_out_instr, s_req_addr;
  int          s_mq_size;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  // One clock cycle: sample and score at negedge, advance memory model after the edge.
  task automatic tick();
    logic        hs;
    logic [31:0] hs_addr;
    int          c0;
    @(negedge clk);
    c0          = cyc;
    s_out_valid = out_valid;
    s_req_valid = imem_req_valid;
    s_out_pc    = out_pc;
    s_out_inc   = out_pc_inc;
    s_out_instr = out_instr;
    s_req_addr  = imem_req_addr;
    s_mq_size   = mq.size();
    hs          = imem_req_valid && imem_req_ready;
    hs_addr     = imem_req_addr;
    if (!rst) begin
      if (redirect_valid) begin
        tests++;
        if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
          fails++;
          $display("FAIL redirect_quiet: out_valid=%b req_valid=%b, required 0 and 0", out_valid, imem_req_valid);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (out_pc !== exp_pc || out_instr !== mem_word(exp_pc) || out_pc_inc !== exp_pc + 32'd4) begin
          fails++;
          $display("FAIL pop_stream: pc=%h instr=%h inc=%h, required pc=%h instr=%h inc=%h",
                   out_pc, out_instr, out_pc_inc, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
        end
        pop_pc_log.push_back(out_pc);
        pop_inc_log.push_back(out_pc_inc);
        exp_pc = exp_pc + 32'd4;
        n_pops++;
      end
      if (out_ready && !out_valid) n_bubbles++;
      if (redirect_valid) exp_pc = redirect_addr;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      mq.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else begin
      if (hs) mq.push_back('{due: c0 + latency, data: mem_word(hs_addr)});
      if (mq.size() > 0 && mq[0].due == cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mq[0].data;
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
      end
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
    exp_pc = RESET_PC;
    n_pops = 0;
    n_bubbles = 0;
    pop_pc_log.delete();
    pop_inc_log.delete();
  endtask

  task automatic test_reset_stream();
    latency = 1;
    do_reset();
    tests++;
    if (s_out_valid !== 1'b0 || s_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valids: out_valid=%b req_valid=%b, required 0 and 0", s_out_valid, s_req_valid);
    end
    tests++;
    if (s_out_pc !== RESET_PC || s_out_inc !== RESET_PC + 32'd4 || s_out_instr !== 32'd0) begin
      fails++;
      $display("FAIL reset_fields: pc=%h inc=%h instr=%h, required %h %h 0", s_out_pc, s_out_inc, s_out_instr,
               RESET_PC, RESET_PC + 32'd4);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) begin
        tests++;
        if (s_req_valid !== 1'b1 || s_req_addr !== RESET_PC) begin
          fails++;
          $display("FAIL first_req: valid=%b addr=%h, required 1 %h", s_req_valid, s_req_addr, RESET_PC);
        end
      end
      tests++;
      if (s_out_valid !== (i >= 2) || (i >= 2 && s_out_pc !== RESET_PC + 32'(4 * (i - 2)))) begin
        fails++;
        $display("FAIL stream_timing: cycle %0d out_valid=%b pc=%h, required valid=%b pc=%h", i, s_out_valid,
                 s_out_pc, (i >= 2), RESET_PC + 32'(4 * (i - 2)));
      end
    end
  endtask

  task automatic test_backpressure();
    int p0;
    latency = 1;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    tests++;
    if (dut.fifo_count !== 3'd4 || dut.outstanding !== 3'd0 || s_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_full: count=%0d outstanding=%0d req_valid=%b, required 4 0 0", dut.fifo_count,
               dut.outstanding, s_req_valid);
    end
    p0 = n_pops;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    tests++;
    if (n_pops - p0 !== 12) begin
      fails++;
      $display("FAIL bp_release: pops=%0d, required 12", n_pops - p0);
    end
  endtask

  task automatic test_redirect_inflight();
    latency = 3;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_2000;
    tick();
    redirect_valid = 1'b0;
    tests++;
    if (dut.drop_cnt !== 3'(s_mq_size) || s_mq_size != 2) begin
      fails++;
      $display("FAIL inflight_drop: drop_cnt=%0d, required %0d (model in-flight %0d, expected 2)", dut.drop_cnt,
               s_mq_size, s_mq_size);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 1) begin
        tests++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0000_2000) begin
          fails++;
          $display("FAIL redirect_req: valid=%b addr=%h, required 1 00002000", s_req_valid, s_req_addr);
        end
      end
      tests++;
      if (s_out_valid !== (i == 5) || (i == 5 && s_out_pc !== 32'h0000_2000)) begin
        fails++;
        $display("FAIL redirect_latency: t+%0d out_valid=%b pc=%h, required valid=%b pc=00002000", i,
                 s_out_valid, s_out_pc, (i == 5));
      end
    end
  endtask

  task automatic test_redirect_coincide();
    int p0;
    latency = 2;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    p0 = n_pops;
    redirect_valid = 1'b1;
    redirect_addr  = $urandom & 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tests++;
    if (n_pops !== p0 || dut.drop_cnt !== 3'(s_mq_size) || s_mq_size != 1) begin
      fails++;
      $display("FAIL coincide: pops_in_cycle=%0d drop_cnt=%0d, required 0 and %0d", n_pops - p0, dut.drop_cnt,
               s_mq_size);
    end
`ifdef IF_PERF_CNT_EN
    tests++;
    if (perf_fetched !== 32'(n_pops)) begin
      fails++;
      $display("FAIL coincide_perf: perf_fetched=%0d, required %0d", perf_fetched, n_pops);
    end
`endif
    for (int i = 0; i < 10; i++) tick();
    tests++;
    if (n_pops - p0 < 5) begin
      fails++;
      $display("FAIL coincide_resume: pops=%0d, required at least 5", n_pops - p0);
    end
  endtask

  task automatic test_wrap();
    latency = 1;
    do_reset();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    pop_pc_log.delete();
    pop_inc_log.delete();
    for (int i = 0; i < 8; i++) tick();
    tests++;
    if (pop_pc_log.size() < 2) begin
      fails++;
      $display("FAIL wrap_count: pops=%0d, required at least 2", pop_pc_log.size());
    end else if (pop_pc_log[0] !== 32'hFFFF_FFFC || pop_pc_log[1] !== 32'h0 || pop_inc_log[0] !== 32'h0) begin
      fails++;
      $display("FAIL wrap: pc0=%h pc1=%h inc0=%h, required fffffffc 00000000 00000000", pop_pc_log[0],
               pop_pc_log[1], pop_inc_log[0]);
    end
  endtask

  task automatic test_random();
    int p0;
    for (int r = 0; r < 3; r++) begin
      latency = $urandom_range(1, 6);
      do_reset();
      for (int i = 0; i < 600; i++) begin
        redirect_valid = ($urandom_range(0, 15) == 0);
        redirect_addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hC)
                                                     : ($urandom & 32'hFFFF_FFFC);
        imem_req_ready = ($urandom_range(0, 3) != 0);
        out_ready      = ($urandom_range(0, 3) != 0);
        tick();
        tests++;
        if (mq.size() + int'(imem_rsp_valid) > FIFO_DEPTH) begin
          fails++;
          $display("FAIL in_flight_bound: %0d requests in flight, required at most %0d",
                   mq.size() + int'(imem_rsp_valid), FIFO_DEPTH);
        end
      end
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      p0 = n_pops;
      for (int i = 0; i < 30; i++) tick();
      tests++;
      if (n_pops - p0 < 20) begin
        fails++;
        $display("FAIL random_drain: pops=%0d, required at least 20 (latency %0d)", n_pops - p0, latency);
      end
`ifdef IF_PERF_CNT_EN
      tests++;
      if (perf_fetched !== 32'(n_pops) || perf_bubble !== 32'(n_bubbles)) begin
        fails++;
        $display("FAIL random_perf: fetched=%0d bubble=%0d, required %0d %0d", perf_fetched, perf_bubble,
                 n_pops, n_bubbles);
      end
`endif
    end
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    latency = 1;
    do_reset();
    tests++;
    if (perf_fetched !== 32'd0 || perf_bubble !== 32'd0) begin
      fails++;
      $display("FAIL perf_reset: fetched=%0d bubble=%0d, required 0 0", perf_fetched, perf_bubble);
    end
    imem_req_ready = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    imem_req_ready = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    imem_req_ready = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    imem_req_ready = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if (perf_fetched !== 32'd5 || perf_bubble !== 32'd3) begin
      fails++;
      $display("FAIL perf_counts: fetched=%0d bubble=%0d, required 5 3", perf_fetched, perf_bubble);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    cyc = 0;
    latency = 1;
    test_reset_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_coincide();
    test_wrap();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
